branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage branch resolution unit. It is the closing end of the decode-stage predict/update loop.
- Computes the actual outcome and target of every branch/jump and compares them with the decode-stage prediction.
- Emits the 2-bit predictor training code (false_branch) back to decode.
- On a mispredict, drives a redirect/flush handshake toward fetch, and keeps branch and mispredict statistics.

Parameters:
- XLEN, 64, data/PC width.
- CNT_W, 32, width of statistics counters (saturating).
- DRAIN_CYCLES, 1, flush cycles held after redirect is accepted (1..3).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  execute-stage instruction valid.
- stall  in  1  execute stage stalled; no resolution this cycle.
- is_branch  in  1  conditional branch (op B).
- is_jump  in  1  JAL/JALR (op J).
- is_jalr  in  1  register-indirect jump (alusrc set on J).
- funct3  in  3  branch condition.
- srca, srcb  in  XLEN  register operands.
- imm  in  XLEN  sign-extended immediate.
- pc  in  XLEN  instruction PC.
- pred_taken  in  1  decode prediction (branch && branchorjump).
- pred_target  in  XLEN  decode-computed target (pc_branch).
- fetch_ready  in  1  fetch accepts redirect this cycle.
- false_branch  out  2  predictor training code.
- redirect_valid  out  1  corrected PC is valid.
- redirect_pc  out  XLEN  corrected fetch PC.
- flush  out  1  squash IF/ID wrong-path instructions.
- busy  out  1  unit is not in IDLE.
- branch_cnt  out  CNT_W  resolved branches and jumps.
- mispred_cnt  out  CNT_W  mispredicts.

Behaviour:
- Resolve event: in_valid && !stall && (is_branch || is_jump) && state==IDLE. Inputs are ignored when state!=IDLE.
- Condition, decoded from funct3:
  - 000 EQ; 001 NE; 100 signed LT; 101 signed GE; 110 unsigned LT; 111 unsigned GE.
  - 010 and 011 count as not taken.
  - A jump is always taken.
- Actual target, XLEN wrap-around arithmetic:
  - JALR: (srca+imm) & ~1.
  - Otherwise: pc+imm.
  - Fall-through: pc+4.
- Mispredict when actual_taken != pred_taken, or when actual_taken && pred_target != actual_target.
- Correct PC: actual target if taken, else pc+4.
- false_branch (registered, 1-cycle latency):
  - The cycle after a resolve event: 2'b11 if actual taken, 2'b00 if not taken.
  - 2'b01 (hold) at all other times, and at reset.
  - Asserted for exactly one cycle per resolve event.
- FSM states: IDLE, REDIRECT, DRAIN.
  - IDLE -> REDIRECT on a resolve event with mispredict. redirect_pc is registered with the correct PC at that edge.
  - REDIRECT: redirect_valid=1 and flush=1. redirect_pc is held stable until fetch_ready==1.
  - On a fetch_ready cycle: DRAIN with drain counter = DRAIN_CYCLES-1, or IDLE if DRAIN_CYCLES==1... more precisely: if DRAIN_CYCLES==1, go to DRAIN for one cycle and then IDLE.
  - DRAIN: flush=1 and redirect_valid=0. The counter decrements; at 0 the FSM returns to IDLE.
  - busy=1 in REDIRECT and DRAIN.
  - Correct prediction: FSM stays in IDLE, with no flush and no redirect.
- stall high while in REDIRECT or DRAIN does not freeze the FSM. Redirect progress depends only on fetch_ready.
- Counters:
  - branch_cnt increments on each resolve event.
  - mispred_cnt increments on each mispredicting resolve event.
  - Both saturate at all-ones and never wrap.
- Reset values:
  - state=IDLE; false_branch=2'b01; redirect_valid=0; redirect_pc=0; flush=0; busy=0; counters=0.
- Reset mid-redirect: the FSM returns to IDLE on the next edge, and redirect_valid drops immediately after that edge.
- Non-branch instructions, or in_valid=0: no event, counters unchanged.

Test Plan:
- BEQ, srca=srcb=5, pc=0x1000, imm=0x40, pred_taken=0 -> next cycle false_branch=11. redirect_valid=1 with redirect_pc=0x1040 held until fetch_ready. Then flush for 1 DRAIN cycle, then IDLE. mispred_cnt=1.
- BLT, srca=-1, srcb=1, pred_taken=1, pred_target=pc+imm -> false_branch=11, no redirect, branch_cnt+1, mispred_cnt unchanged. Repeat with BLTU -> not taken, so mispredict with redirect_pc=pc+4 and false_branch=00.
- JALR, srca=0x2003, imm=4, pred_taken=1, pred_target=0x2008 -> target 0x2006, mispredict, redirect_pc=0x2006.
- fetch_ready held low 5 cycles during REDIRECT, with new in_valid branches presented -> redirect_pc stable, inputs ignored, counters unchanged. Accept on cycle 6.
- Assert reset while in REDIRECT -> next cycle all outputs at reset values, false_branch=01.
- Force branch_cnt to all-ones (CNT_W=4, 16 events) -> the count saturates at 0xF.

Source files
------------

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: computes the actual branch/jump outcome,
// trains the decode predictor, and runs the redirect/flush handshake to fetch.
module branch_resolve #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  srca,
  input  logic [XLEN-1:0]  srcb,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  input  logic             fetch_ready,
  output logic [1:0]       false_branch,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned DRN_W = 2;

  localparam logic [1:0] FB_HOLD      = 2'b01;
  localparam logic [1:0] FB_TAKEN     = 2'b11;
  localparam logic [1:0] FB_NOT_TAKEN = 2'b00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DRN_W-1:0] drain_cnt;
  logic [DRN_W-1:0] drain_cnt_nxt;

  logic             resolve;
  logic             cond_taken;
  logic             actual_taken;
  logic             mispredict;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  actual_target;
  logic [XLEN-1:0]  fall_through;
  logic [XLEN-1:0]  correct_pc;

  // Branch condition decode; reserved encodings resolve as not taken.
  always_comb begin
    cond_taken = 1'b0;
    case (funct3)
      3'b000:  cond_taken = (srca == srcb);
      3'b001:  cond_taken = (srca != srcb);
      3'b100:  cond_taken = ($signed(srca) <  $signed(srcb));
      3'b101:  cond_taken = ($signed(srca) >= $signed(srcb));
      3'b110:  cond_taken = (srca <  srcb);
      3'b111:  cond_taken = (srca >= srcb);
      default: cond_taken = 1'b0;
    endcase
  end

  // Actual outcome, target and mispredict detection.
  always_comb begin
    resolve       = in_valid && !stall && (is_branch || is_jump) && (state == IDLE);
    actual_taken  = is_jump || cond_taken;
    jalr_sum      = srca + imm;
    fall_through  = pc + XLEN'(4);
    actual_target = (is_jump && is_jalr) ? {jalr_sum[XLEN-1:1], 1'b0} : (pc + imm);
    correct_pc    = actual_taken ? actual_target : fall_through;
    mispredict    = (actual_taken != pred_taken) ||
                    (actual_taken && (pred_target != actual_target));
  end

  // Redirect FSM next-state: fetch_ready alone advances REDIRECT, stall is ignored.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (resolve && mispredict) state_nxt = REDIRECT;
      end
      REDIRECT: begin
        if (fetch_ready) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRN_W'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = IDLE;
        else                 drain_cnt_nxt = drain_cnt - DRN_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Registered handshake outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= (state_nxt == REDIRECT);
      flush          <= (state_nxt != IDLE);
      busy           <= (state_nxt != IDLE);
      if (resolve && mispredict) redirect_pc <= correct_pc;
    end
  end

  // Predictor training code: one-cycle pulse per resolve, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset)        false_branch <= FB_HOLD;
    else if (resolve) false_branch <= actual_taken ? FB_TAKEN : FB_NOT_TAKEN;
    else              false_branch <= FB_HOLD;
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (resolve) begin
      if (branch_cnt != '1)                mispred_cnt <= mispred_cnt;
      if (branch_cnt != '1)                branch_cnt  <= branch_cnt + CNT_W'(1);
      if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a scoreboard of expected resolve results.
module tb_branch_resolve;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, stall, is_branch, is_jump, is_jalr;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  srca, srcb, imm, pc, pred_target;
  logic             pred_taken, fetch_ready;
  logic [1:0]       false_branch;
  logic             redirect_valid, flush, busy;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W), .DRAIN_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall),
    .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr), .funct3(funct3),
    .srca(srca), .srcb(srcb), .imm(imm), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .fetch_ready(fetch_ready),
    .false_branch(false_branch), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  fb;
    logic        rv;
    logic [63:0] rpc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned m_bc  = 0;
  int unsigned m_mc  = 0;
  logic [63:0] m_rpc = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".branch_cnt"},  64'(branch_cnt),  64'(m_bc));
    chk({tag, ".mispred_cnt"}, 64'(mispred_cnt), 64'(m_mc));
  endtask

  function automatic logic m_cond(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) <  $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a <  b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    in_valid = 0; stall = 0; is_branch = 0; is_jump = 0; is_jalr = 0;
  endtask

  // Drive one resolve event, push its expectation, then pop and compare after the edge.
  task automatic br(input string tag, input logic ij, input logic ijr, input logic [2:0] f3,
                    input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                    input logic [63:0] p, input logic pt, input logic [63:0] ptg);
    logic        tk, mp;
    logic [63:0] tgt, cpc;
    exp_t        e;
    in_valid = 1; stall = 0; is_branch = !ij; is_jump = ij; is_jalr = ijr; funct3 = f3;
    srca = a; srcb = b; imm = im; pc = p; pred_taken = pt; pred_target = ptg;
    tk = ij ? 1'b1 : m_cond(f3, a, b);
    if (ij && ijr) begin tgt = a + im; tgt[0] = 1'b0; end
    else           tgt = p + im;
    cpc = tk ? tgt : p + 64'd4;
    mp  = (tk != pt) || (tk && (ptg != tgt));
    if (m_bc < CMAX) m_bc++;
    if (mp && m_mc < CMAX) m_mc++;
    if (mp) m_rpc = cpc;
    e.fb = tk ? 2'b11 : 2'b00; e.rv = mp; e.rpc = m_rpc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    idle_inputs();
    e = exp_q.pop_front();
    chk({tag, ".false_branch"},   64'(false_branch),   64'(e.fb));
    chk({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(e.rv));
    chk({tag, ".redirect_pc"},    redirect_pc,         e.rpc);
    chk({tag, ".flush"},          64'(flush),          64'(e.rv));
    chk({tag, ".busy"},           64'(busy),           64'(e.rv));
    chk_cnt(tag);
  endtask

  // Quiet cycle in IDLE: training code returns to hold.
  task automatic idle_chk(input string tag);
    idle_inputs();
    @(posedge clk); #1;
    chk({tag, ".fb_hold"}, 64'(false_branch), 64'(2'b01));
    chk({tag, ".flush"},   64'(flush),        64'd0);
  endtask

  // Hold fetch_ready low while offering branches (must be ignored), then accept and drain.
  task automatic accept(input string tag, input int low);
    for (int i = 0; i < low; i++) begin
      in_valid = 1; is_branch = 1; is_jump = 0; is_jalr = 0; funct3 = 3'b000;
      srca = 64'(i); srcb = 64'(i); imm = 64'h80; pc = 64'h9000; pred_taken = 0;
      stall = (i % 2 == 1); fetch_ready = 0;
      @(posedge clk); #1;
      chk({tag, ".wait_rv"},  64'(redirect_valid), 64'd1);
      chk({tag, ".wait_pc"},  redirect_pc,         m_rpc);
      chk({tag, ".wait_fb"},  64'(false_branch),   64'(2'b01));
      chk({tag, ".wait_fl"},  64'(flush),          64'd1);
      chk_cnt({tag, ".wait"});
    end
    in_valid = 0; stall = 1; fetch_ready = 1;
    @(posedge clk); #1;
    fetch_ready = 0; stall = 0;
    chk({tag, ".drain_rv"},   64'(redirect_valid), 64'd0);
    chk({tag, ".drain_fl"},   64'(flush),          64'd1);
    chk({tag, ".drain_busy"}, 64'(busy),           64'd1);
    chk({tag, ".drain_pc"},   redirect_pc,         m_rpc);
    in_valid = 1; is_branch = 1;
    @(posedge clk); #1;
    idle_inputs();
    chk({tag, ".idle_fl"},   64'(flush),        64'd0);
    chk({tag, ".idle_busy"}, 64'(busy),         64'd0);
    chk({tag, ".idle_fb"},   64'(false_branch), 64'(2'b01));
    chk_cnt({tag, ".idle"});
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, ".fb"},   64'(false_branch),   64'(2'b01));
    chk({tag, ".rv"},   64'(redirect_valid), 64'd0);
    chk({tag, ".pc"},   redirect_pc,         64'd0);
    chk({tag, ".fl"},   64'(flush),          64'd0);
    chk({tag, ".busy"}, 64'(busy),           64'd0);
    chk_cnt(tag);
  endtask

  initial begin
    reset = 1; idle_inputs(); fetch_ready = 0; funct3 = 0;
    srca = 0; srcb = 0; imm = 0; pc = 0; pred_taken = 0; pred_target = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_chk("reset");
    reset = 0;

    br("beq_mp", 0, 0, 3'b000, 64'd5, 64'd5, 64'h40, 64'h1000, 0, 64'd0);
    accept("beq_mp", 5);
    br("blt_ok", 0, 0, 3'b100, '1, 64'd1, 64'h20, 64'h3000, 1, 64'h3020);
    idle_chk("blt_ok");
    br("bltu_mp", 0, 0, 3'b110, '1, 64'd1, 64'h20, 64'h3000, 1, 64'h3020);
    accept("bltu_mp", 0);
    br("jalr_mp", 1, 1, 3'b000, 64'h2003, 64'd0, 64'd4, 64'h500, 1, 64'h2008);
    accept("jalr_mp", 2);
    br("bne_ok", 0, 0, 3'b001, 64'd7, 64'd7, 64'h10, 64'h600, 0, 64'd0);
    br("bge_ok", 0, 0, 3'b101, -64'sd5, -64'sd5, 64'h30, 64'h700, 1, 64'h730);
    br("f010_ok", 0, 0, 3'b010, 64'd1, 64'd2, 64'h30, 64'h800, 0, 64'd0);
    br("jal_wrap", 1, 0, 3'b000, 64'd0, 64'd0, -64'sd32, 64'h10, 1, 64'h30);
    accept("jal_wrap", 1);
    br("bgeu_ok", 0, 0, 3'b111, 64'd9, 64'd3, 64'h8, 64'hA00, 1, 64'hA08);

    // Non-branch and stalled branch produce no event.
    in_valid = 1; is_branch = 0; is_jump = 0;
    @(posedge clk); #1;
    chk("nonbr.fb", 64'(false_branch), 64'(2'b01));
    chk_cnt("nonbr");
    in_valid = 1; is_branch = 1; stall = 1; funct3 = 3'b000; srca = 1; srcb = 1; pred_taken = 0;
    @(posedge clk); #1;
    idle_inputs();
    chk("stall.fb", 64'(false_branch), 64'(2'b01));
    chk("stall.rv", 64'(redirect_valid), 64'd0);
    chk_cnt("stall");

    // Reset while a redirect is pending.
    br("pre_rst", 0, 0, 3'b000, 64'd3, 64'd3, 64'h100, 64'hB00, 0, 64'd0);
    reset = 1;
    @(posedge clk); #1;
    m_bc = 0; m_mc = 0; m_rpc = 64'd0;
    rst_chk("mid_rst");
    reset = 0;

    // Saturation of branch_cnt at all-ones.
    for (int i = 0; i < 17; i++)
      br("sat", 0, 0, 3'b000, 64'(i), 64'(i + 1), 64'h40, 64'hC00, 0, 64'd0);
    chk("sat.final", 64'(branch_cnt), 64'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
